// File: rtl/xge_pkt_stream_checker_if.sv
// Passive tap bundle for one MAC pkt_* stream: the source drives it through
// the master modport, checkers and monitors observe it through the slave modport.
interface xge_pkt_stream_checker_if #(
    parameter int DATA_W = 64,
    parameter int MOD_W  = 3
);
    logic              pkt_val;
    logic              pkt_sop;
    logic              pkt_eop;
    logic [MOD_W-1:0]  pkt_mod;
    logic              pkt_err;
    logic [DATA_W-1:0] pkt_data;

    modport master (
        output pkt_val, pkt_sop, pkt_eop, pkt_mod, pkt_err, pkt_data
    );

    modport slave (
        input pkt_val, pkt_sop, pkt_eop, pkt_mod, pkt_err, pkt_data
    );
endinterface

// File: rtl/xge_pkt_stream_checker.sv
// Passive protocol checker and saturating statistics for one pkt_* stream.
// Define XGE_CHK_LEN_EN to build the MIN_LEN/MAX_LEN frame-length checks (codes 4 and 5).
module xge_pkt_stream_checker #(
    parameter int DATA_W  = 64,
    parameter int MOD_W   = 3,
    parameter int CNT_W   = 32,
    parameter int LEN_W   = 16,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 9600
) (
    input  logic                     clk_156m25,
    input  logic                     reset_156m25_n,
    xge_pkt_stream_checker_if.slave  pkt,
    input  logic                     clr_i,
    output logic                     in_pkt_o,
    output logic                     viol_o,
    output logic [2:0]               viol_code_o,
    output logic [7:0]               viol_sticky_o,
    output logic [CNT_W-1:0]         pkt_cnt_o,
    output logic [CNT_W-1:0]         err_pkt_cnt_o,
    output logic [CNT_W-1:0]         byte_cnt_o,
    output logic [CNT_W-1:0]         viol_cnt_o
);
    localparam int BPB = DATA_W / 8;
    localparam int SW  = ((CNT_W > LEN_W) ? CNT_W : LEN_W) + 1;

    typedef enum logic {S_IDLE, S_IN_PKT} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               taint_q, taint_d;
    logic               in_pkt_q, in_pkt_d;
    logic               viol_q, viol_d;
    logic [2:0]         code_q, code_d;
    logic [7:0]         sticky_q, sticky_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]   viol_cnt_q, viol_cnt_d;

    logic               accept, restart, frame_bad, taint_base;
    logic [7:0]         codes;
    logic [2:0]         low_code;
    logic [LEN_W-1:0]   beat_bytes, len_base, len_new;
    logic [LEN_W:0]     len_sum;
    logic [SW-1:0]      byte_sum;

`ifdef XGE_CHK_LEN_EN
    localparam logic [31:0] MIN_LEN_C = 32'(MIN_LEN);
    localparam logic [31:0] MAX_LEN_C = 32'(MAX_LEN);
    logic over_q, over_d, over_base;
`else
    logic unused_len_cfg;
    assign unused_len_cfg = (MIN_LEN > MAX_LEN);
`endif

    logic unused_data;
    assign unused_data = ^pkt.pkt_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        codes      = 8'd0;
        low_code   = 3'd0;
        // A beat belongs to a frame only if it opens one or continues an open one.
        accept     = pkt.pkt_val && (pkt.pkt_sop || state_q == S_IN_PKT);
        restart    = pkt.pkt_val && pkt.pkt_sop;
        beat_bytes = (pkt.pkt_eop && pkt.pkt_mod != '0) ? LEN_W'(pkt.pkt_mod) : LEN_W'(BPB);
        len_base   = restart ? '0 : len_q;
        taint_base = restart ? 1'b0 : taint_q;
        len_sum    = {1'b0, len_base} + {1'b0, beat_bytes};
        len_new    = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];

        codes[1] = pkt.pkt_val && pkt.pkt_sop && state_q == S_IN_PKT;
        codes[2] = pkt.pkt_val && !pkt.pkt_sop && state_q == S_IDLE;
        codes[3] = accept && !pkt.pkt_eop && pkt.pkt_mod != '0;
`ifdef XGE_CHK_LEN_EN
        over_base = restart ? 1'b0 : over_q;
        codes[4]  = accept && !over_base && (32'(len_new) > MAX_LEN_C);
        codes[5]  = accept && pkt.pkt_eop && (32'(len_new) < MIN_LEN_C);
        over_d    = accept ? (over_base | codes[4]) : over_q;
`endif
        // Code 1 blames the dropped frame, so it does not taint the restarted one.
        frame_bad = taint_base | codes[3] | codes[4] | codes[5];

        for (int n = 7; n >= 1; n--) begin
            if (codes[n]) low_code = 3'(n);
        end

        if (pkt.pkt_val && pkt.pkt_sop)
            state_d = pkt.pkt_eop ? S_IDLE : S_IN_PKT;
        else if (pkt.pkt_val && pkt.pkt_eop && state_q == S_IN_PKT)
            state_d = S_IDLE;

        len_d    = accept ? len_new : len_q;
        taint_d  = accept ? frame_bad : taint_q;
        in_pkt_d = (state_d == S_IN_PKT);
        viol_d   = |codes;

        byte_sum = SW'(byte_cnt_q) + SW'(len_new);

        pkt_cnt_d  = pkt_cnt_q;
        err_cnt_d  = err_cnt_q;
        byte_cnt_d = byte_cnt_q;
        viol_cnt_d = viol_cnt_q;
        code_d     = code_q;
        sticky_d   = sticky_q | codes;
        if (accept && pkt.pkt_eop && !pkt.pkt_err && !frame_bad) begin
            pkt_cnt_d  = sat_inc(pkt_cnt_q);
            byte_cnt_d = (|byte_sum[SW-1:CNT_W]) ? '1 : byte_sum[CNT_W-1:0];
        end
        if (accept && pkt.pkt_eop && pkt.pkt_err)
            err_cnt_d = sat_inc(err_cnt_q);
        if (|codes) begin
            viol_cnt_d = sat_inc(viol_cnt_q);
            code_d     = low_code;
        end
        // Clear beats any same-cycle increment; the FSM keeps tracking the beat.
        if (clr_i) begin
            pkt_cnt_d  = '0;
            err_cnt_d  = '0;
            byte_cnt_d = '0;
            viol_cnt_d = '0;
            code_d     = 3'd0;
            sticky_d   = 8'd0;
        end
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            taint_q    <= 1'b0;
            in_pkt_q   <= 1'b0;
            viol_q     <= 1'b0;
            code_q     <= 3'd0;
            sticky_q   <= 8'd0;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
            byte_cnt_q <= '0;
            viol_cnt_q <= '0;
`ifdef XGE_CHK_LEN_EN
            over_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            taint_q    <= taint_d;
            in_pkt_q   <= in_pkt_d;
            viol_q     <= viol_d;
            code_q     <= code_d;
            sticky_q   <= sticky_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_cnt_q  <= err_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            viol_cnt_q <= viol_cnt_d;
`ifdef XGE_CHK_LEN_EN
            over_q     <= over_d;
`endif
        end
    end

    assign in_pkt_o      = in_pkt_q;
    assign viol_o        = viol_q;
    assign viol_code_o   = code_q;
    assign viol_sticky_o = sticky_q;
    assign pkt_cnt_o     = pkt_cnt_q;
    assign err_pkt_cnt_o = err_cnt_q;
    assign byte_cnt_o    = byte_cnt_q;
    assign viol_cnt_o    = viol_cnt_q;
endmodule

// File: tb/tb_xge_pkt_stream_checker.sv
// Scoreboard bench: expected per-test statistics are queued with the stimulus and
// popped when the DUT has settled; a CNT_W=4 instance on the same tap covers saturation.
`timescale 1ns/1ps
module tb_xge_pkt_stream_checker;
`ifdef XGE_CHK_LEN_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    always #3.2 clk = ~clk;

    xge_pkt_stream_checker_if #(.DATA_W(64), .MOD_W(3)) pif ();

    logic        in_pkt, viol, s_in_pkt, s_viol;
    logic [2:0]  code, s_code;
    logic [7:0]  sticky, s_sticky;
    logic [31:0] pkt_cnt, err_cnt, byte_cnt, viol_cnt;
    logic [3:0]  s_pkt_cnt, s_err_cnt, s_byte_cnt, s_viol_cnt;

    xge_pkt_stream_checker dut (
        .clk_156m25(clk), .reset_156m25_n(rst_n), .pkt(pif), .clr_i(clr),
        .in_pkt_o(in_pkt), .viol_o(viol), .viol_code_o(code), .viol_sticky_o(sticky),
        .pkt_cnt_o(pkt_cnt), .err_pkt_cnt_o(err_cnt), .byte_cnt_o(byte_cnt), .viol_cnt_o(viol_cnt)
    );

    xge_pkt_stream_checker #(.CNT_W(4)) dut_s (
        .clk_156m25(clk), .reset_156m25_n(rst_n), .pkt(pif), .clr_i(clr),
        .in_pkt_o(s_in_pkt), .viol_o(s_viol), .viol_code_o(s_code), .viol_sticky_o(s_sticky),
        .pkt_cnt_o(s_pkt_cnt), .err_pkt_cnt_o(s_err_cnt), .byte_cnt_o(s_byte_cnt), .viol_cnt_o(s_viol_cnt)
    );

    typedef struct {
        string tag;
        int    pkt;
        int    errp;
        int    bytes;
        int    viols;
        int    code;
        int    sticky;
        int    pulses;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pulses = 0;
    int   beat_no = 0;
    int   last_viol_beat = 0;

    always @(negedge clk) if (viol === 1'b1) pulses++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic sop, input logic eop, input logic [2:0] mod,
                        input logic err, input logic c);
        @(negedge clk);
        pif.pkt_val  = 1'b1;
        pif.pkt_sop  = sop;
        pif.pkt_eop  = eop;
        pif.pkt_mod  = mod;
        pif.pkt_err  = err;
        pif.pkt_data = {$urandom(), $urandom()};
        clr = c;
        @(posedge clk);
        #1;
        pif.pkt_val = 1'b0;
        clr = 1'b0;
        beat_no++;
        if (viol === 1'b1) last_viol_beat = beat_no;
    endtask

    task automatic frame(input int nbeats, input logic [2:0] emod, input logic err);
        for (int i = 0; i < nbeats; i++) begin
            beat(i == 0, i == nbeats - 1, (i == nbeats - 1) ? emod : 3'd0, err, 1'b0);
        end
    endtask

    task automatic clear_stats();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        pulses = 0;
        beat_no = 0;
        last_viol_beat = 0;
    endtask

    task automatic push_exp(input string tag, input int p, input int e, input int b,
                            input int v, input int cd, input int st, input int pu);
        exp_t x;
        x.tag = tag; x.pkt = p; x.errp = e; x.bytes = b;
        x.viols = v; x.code = cd; x.sticky = st; x.pulses = pu;
        exp_q.push_back(x);
    endtask

    task automatic check_stats();
        exp_t x;
        repeat (2) @(negedge clk);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'd0, 64'd1);
            return;
        end
        x = exp_q.pop_front();
        $display("check %s: pkt=%0d err=%0d bytes=%0d viol=%0d code=%0d sticky=%02h pulses=%0d",
                 x.tag, pkt_cnt, err_cnt, byte_cnt, viol_cnt, code, sticky, pulses);
        chk({x.tag, ".pkt_cnt"},     64'(pkt_cnt),  64'(x.pkt));
        chk({x.tag, ".err_pkt_cnt"}, 64'(err_cnt),  64'(x.errp));
        chk({x.tag, ".byte_cnt"},    64'(byte_cnt), 64'(x.bytes));
        chk({x.tag, ".viol_cnt"},    64'(viol_cnt), 64'(x.viols));
        chk({x.tag, ".viol_code"},   64'(code),     64'(x.code));
        chk({x.tag, ".viol_sticky"}, 64'(sticky),   64'(x.sticky));
        chk({x.tag, ".viol_pulses"}, 64'(pulses),   64'(x.pulses));
        chk({x.tag, ".in_pkt"},      64'(in_pkt),   64'd0);
    endtask

    initial begin
        pif.pkt_val = 1'b0; pif.pkt_sop = 1'b0; pif.pkt_eop = 1'b0;
        pif.pkt_mod = 3'd0; pif.pkt_err = 1'b0; pif.pkt_data = '0;
        repeat (3) @(negedge clk);
        chk("reset.in_pkt", 64'(in_pkt), 64'd0);
        chk("reset.viol", 64'(viol), 64'd0);
        chk("reset.pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("reset.sticky", 64'(sticky), 64'd0);
        rst_n = 1'b1;
        clear_stats();

        // T1: 8-beat frame, mod=3 on eop -> 59 bytes (a runt when length checks exist)
        for (int i = 0; i < 8; i++) begin
            beat(i == 0, i == 7, (i == 7) ? 3'd3 : 3'd0, 1'b0, 1'b0);
            if (i == 3) chk("t1.in_pkt_mid", 64'(in_pkt), 64'd1);
        end
        push_exp("t1_good59", LEN_EN ? 0 : 1, 0, LEN_EN ? 0 : 59, LEN_EN ? 1 : 0,
                 LEN_EN ? 5 : 0, LEN_EN ? 'h20 : 0, LEN_EN ? 1 : 0);
        check_stats();

        // T2: sop inside a frame drops the first frame; the restarted 64-byte frame counts
        clear_stats();
        beat(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("t2.viol_after_sop", 64'(viol), 64'd1);
        chk("t2.code_after_sop", 64'(code), 64'd1);
        beat(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("t2.viol_one_cycle", 64'(viol), 64'd0);
        for (int i = 0; i < 5; i++) beat(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        beat(1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        push_exp("t2_sop_in_pkt", 1, 0, 64, 1, 1, 'h02, 1);
        check_stats();

        // T3: stray eop in IDLE, then single-beat sop&eop mod=0 (8 bytes)
        clear_stats();
        beat(1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        frame(1, 3'd0, 1'b0);
        push_exp("t3_stray_eop", LEN_EN ? 0 : 1, 0, LEN_EN ? 0 : 8, LEN_EN ? 2 : 1,
                 LEN_EN ? 5 : 2, LEN_EN ? 'h24 : 'h04, LEN_EN ? 2 : 1);
        check_stats();

        // Codes 1 and 3 on the same beat: one pulse, lowest code, both sticky bits, frame tainted
        clear_stats();
        beat(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 3'd5, 1'b0, 1'b0);
        chk("multi.code_lowest", 64'(code), 64'd1);
        for (int i = 0; i < 6; i++) beat(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        beat(1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        push_exp("multi_code", 0, 0, 0, 1, 1, 'h0A, 1);
        check_stats();

        // pkt_err on eop: counted as an error packet only
        clear_stats();
        frame(8, 3'd0, 1'b1);
        push_exp("err_frame", 0, 1, 0, 0, 0, 0, 0);
        check_stats();

        // T4: 9616-byte frame (oversize with length checks) and 9600-byte frame (legal)
        clear_stats();
        frame(1202, 3'd0, 1'b0);
        chk("t4.viol_beat", 64'(last_viol_beat), LEN_EN ? 64'd1201 : 64'd0);
        push_exp("t4_9616", LEN_EN ? 0 : 1, 0, LEN_EN ? 0 : 9616, LEN_EN ? 1 : 0,
                 LEN_EN ? 4 : 0, LEN_EN ? 'h10 : 0, LEN_EN ? 1 : 0);
        check_stats();
        clear_stats();
        frame(1200, 3'd0, 1'b0);
        push_exp("t4_9600", 1, 0, 9600, 0, 0, 0, 0);
        check_stats();

        // T5: 20 good frames saturate the 4-bit counters; clr on an eop beat wins
        clear_stats();
        for (int f = 0; f < 20; f++) frame(8, 3'd0, 1'b0);
        repeat (2) @(negedge clk);
        chk("t5.sat_pkt_cnt", 64'(s_pkt_cnt), 64'd15);
        chk("t5.sat_byte_cnt", 64'(s_byte_cnt), 64'd15);
        chk("t5.wide_pkt_cnt", 64'(pkt_cnt), 64'd20);
        chk("t5.wide_byte_cnt", 64'(byte_cnt), 64'd1280);
        for (int i = 0; i < 7; i++) beat(i == 0, 1'b0, 3'd0, 1'b0, 1'b0);
        beat(1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
        chk("t5.clr_sat_pkt", 64'(s_pkt_cnt), 64'd0);
        chk("t5.clr_pkt", 64'(pkt_cnt), 64'd0);
        chk("t5.clr_byte", 64'(byte_cnt), 64'd0);
        chk("t5.clr_in_pkt", 64'(in_pkt), 64'd0);
        $display("check t5_saturate_clear: s_pkt=%0d pkt=%0d", s_pkt_cnt, pkt_cnt);

        // T6: reset mid-frame, then a non-sop beat is a code 2
        clear_stats();
        frame(8, 3'd0, 1'b0);
        beat(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("t6.pre_in_pkt", 64'(in_pkt), 64'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6.rst_in_pkt", 64'(in_pkt), 64'd0);
        chk("t6.rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("t6.rst_byte_cnt", 64'(byte_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        @(negedge clk);
        beat(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("t6.viol_pulse", 64'(viol), 64'd1);
        push_exp("t6_after_reset", 0, 0, 0, 1, 2, 'h04, 1);
        check_stats();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
